lvt_mpram: RTL

- Parametrised multi-ported RAM built on a Live Value Table (LVT). Supports NUM_WR write ports and NUM_RD read ports.
- Uses NUM_WR×NUM_RD simple dual-port banks: bank[w][r] is written only by write port w and read only by read port r.
- A per-address LVT records which write port last wrote each address and steers each read port's output mux.
- Successor to the 2W/1R LVT memory. Adds scalable port counts, deterministic write-conflict resolution, selectable read-during-write mode, read-valid flags and conflict statistics.

---
 rtl/lvt_mpram.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lvt_mpram.sv
// lvt_mpram: multi-ported RAM where a live value table steers
// each read port across NUM_WR x NUM_RD simple dual-port banks.
module lvt_mpram #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic                         wr_conflict,
  output logic [15:0]                  conflict_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LVT_W = (NUM_WR > 2) ? $clog2(NUM_WR) : 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [LVT_W-1:0]      sel_t;

  addr_t wa [NUM_WR];
  data_t wd [NUM_WR];
  addr_t ra [NUM_RD];

  data_t mem [NUM_WR][NUM_RD][DEPTH];
  sel_t  lvt [DEPTH];

  data_t bank_q [NUM_WR][NUM_RD];
  sel_t  sel_q [NUM_RD];

  logic [NUM_RD-1:0] hit_d;
  data_t             fwd_d [NUM_RD];
  logic [NUM_RD-1:0] fwd_hit;
  data_t             fwd_data [NUM_RD];

  logic conflict;

  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w] = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
      wd[w] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int r = 0; r < NUM_RD; r++) begin
      ra[r] = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] && wa[i] == wa[j]) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Ascending scan: the highest enabled port matching the address wins.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      hit_d[r] = 1'b0;
      fwd_d[r] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wa[w] == ra[r]) begin
          hit_d[r] = 1'b1;
          fwd_d[r] = wd[w];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WR; w++) begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (wr_en[w]) begin
          mem[w][r][wa[w]] <= wd[w];
        end
      end
    end
  end

  // Later loop iterations override earlier ones on a shared address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        lvt[a] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w]) begin
          lvt[wa[w]] <= sel_t'(w);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= '0;
      fwd_hit  <= '0;
      for (int r = 0; r < NUM_RD; r++) begin
        sel_q[r]    <= '0;
        fwd_data[r] <= '0;
        for (int w = 0; w < NUM_WR; w++) begin
          bank_q[w][r] <= '0;
        end
      end
    end else begin
      rd_valid <= rd_en;
      for (int r = 0; r < NUM_RD; r++) begin
        if (rd_en[r]) begin
          sel_q[r] <= lvt[ra[r]];
          for (int w = 0; w < NUM_WR; w++) begin
            bank_q[w][r] <= mem[w][r][ra[r]];
          end
          if (BYPASS != 0) begin
            fwd_hit[r]  <= hit_d[r];
            fwd_data[r] <= fwd_d[r];
          end
        end
      end
    end
  end

  always_comb begin
    data_t v;
    rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      v = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (sel_q[r] == sel_t'(w)) begin
          v = bank_q[w][r];
        end
      end
      if (fwd_hit[r]) begin
        v = fwd_data[r];
      end
      rd_data[r*DATA_WIDTH +: DATA_WIDTH] = v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_conflict  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      wr_conflict <= conflict;
      if (conflict && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule
